// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, types and helpers for the fetch stage
//
// Contents:
//   FETCH_BYTES           fetch block size in bytes (one aligned 8-byte block per request)
//   OPC_JAL / OPC_BRANCH  opcodes recognised by the static predictor
//   ST_REQ/ST_WAIT/ST_DROP  request FSM state encodings
//   branch_pred_t         prediction result carried with each packet
//   fetch_packet_t        two-slot packet register contents
//   align_pc, imm_j, imm_b  address alignment and immediate extraction helpers
package fetch_pkg;

  localparam int FETCH_BYTES = 8;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_REQ  = 2'd0;  // ready to issue a request
  localparam fetch_state_t ST_WAIT = 2'd1;  // request accepted, response pending
  localparam fetch_state_t ST_DROP = 2'd2;  // pending response belongs to a flushed path

  typedef struct packed {
    logic        pred_valid;
    logic [63:0] pred_target;
    logic        pred_taken;
  } branch_pred_t;

  typedef struct packed {
    logic         valid_0;
    logic         valid_1;
    logic [63:0]  pc;
    logic [31:0]  inst_0;
    logic [31:0]  inst_1;
    branch_pred_t pred;
  } fetch_packet_t;

  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & ~(64'(FETCH_BYTES) - 64'd1);
  endfunction

  // J-type immediate, sign-extended to 64 bits
  function automatic logic [63:0] imm_j(input logic [31:0] i);
    return {{44{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  // B-type immediate, sign-extended to 64 bits
  function automatic logic [63:0] imm_b(input logic [31:0] i);
    return {{52{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// rtl/fetch_predecode.sv - combinational static branch predecode for a two-slot fetch packet
//
// Built only when FETCH_STATIC_PREDICT_EN is defined.
// Ports:
//   inst_0, inst_1          slot instructions (slot 1 sits at base_pc+4)
//   valid_0, valid_1        incoming slot valid bits
//   base_pc                 aligned packet base address
//   pred                    prediction pack (valid / target / taken)
//   valid_out_0/1           slot valid mask after prediction (slot 1 dropped when slot 0 is taken)
//   next_pc                 next fetch address (taken target or base_pc+8)
`ifdef FETCH_STATIC_PREDICT_EN
module fetch_predecode
  import fetch_pkg::*;
(
  input  logic [31:0]  inst_0,
  input  logic [31:0]  inst_1,
  input  logic         valid_0,
  input  logic         valid_1,
  input  logic [63:0]  base_pc,
  output branch_pred_t pred,
  output logic         valid_out_0,
  output logic         valid_out_1,
  output logic [63:0]  next_pc
);

  logic        ctl_0, ctl_1;
  logic        taken_0, taken_1;
  logic [63:0] target_0, target_1;

  always_comb begin
    ctl_0    = valid_0 && (inst_0[6:0] == OPC_JAL || inst_0[6:0] == OPC_BRANCH);
    ctl_1    = valid_1 && (inst_1[6:0] == OPC_JAL || inst_1[6:0] == OPC_BRANCH);
    // backward conditional branches (negative offset) and all JALs are predicted taken
    taken_0  = ctl_0 && (inst_0[6:0] == OPC_JAL || inst_0[31]);
    taken_1  = ctl_1 && (inst_1[6:0] == OPC_JAL || inst_1[31]);
    target_0 = base_pc + ((inst_0[6:0] == OPC_JAL) ? imm_j(inst_0) : imm_b(inst_0));
    target_1 = base_pc + 64'd4 + ((inst_1[6:0] == OPC_JAL) ? imm_j(inst_1) : imm_b(inst_1));

    pred        = '0;
    valid_out_0 = valid_0;
    valid_out_1 = valid_1;
    next_pc     = base_pc + 64'(FETCH_BYTES);

    if (taken_0) begin
      pred.pred_valid  = 1'b1;
      pred.pred_taken  = 1'b1;
      pred.pred_target = target_0;
      valid_out_1      = 1'b0;
      next_pc          = target_0;
    end else if (taken_1) begin
      pred.pred_valid  = 1'b1;
      pred.pred_taken  = 1'b1;
      pred.pred_target = target_1;
      next_pc          = target_1;
    end else if (ctl_0 || ctl_1) begin
      pred.pred_valid  = 1'b1;
    end
  end

endmodule
`endif

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC generation, single-outstanding imem requests, two-slot packet output
//
// Optional feature macro: FETCH_STATIC_PREDICT_EN (static branch prediction via fetch_predecode).
// Ports:
//   clock, reset                 clock; asynchronous active-low reset
//   io_redirect_*                back-end flush/redirect (highest priority), target PC
//   io_imem_req_valid/ready/addr aligned instruction-memory request handshake
//   io_imem_resp_valid/data      memory response, [31:0] slot 0, [63:32] slot 1
//   io_full                      fetch queue back-pressure
//   io_out_valid, io_out_bits_*  packet offered to the fetch queue with prediction pack
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_redirect_valid,
  input  logic [63:0] io_redirect_target,
  output logic        io_imem_req_valid,
  input  logic        io_imem_req_ready,
  output logic [63:0] io_imem_req_addr,
  input  logic        io_imem_resp_valid,
  input  logic [63:0] io_imem_resp_data,
  input  logic        io_full,
  output logic        io_out_valid,
  output logic        io_out_bits_valids_0,
  output logic        io_out_bits_valids_1,
  output logic [63:0] io_out_bits_pc,
  output logic [31:0] io_out_bits_insts_0,
  output logic [31:0] io_out_bits_insts_1,
  output logic        io_out_bits_branch_predict_pack_valid,
  output logic [63:0] io_out_bits_branch_predict_pack_target,
  output logic        io_out_bits_branch_predict_pack_taken
);

  fetch_state_t  state;
  logic [63:0]   fetch_pc;
  logic          pkt_valid;
  fetch_packet_t pkt;

  logic          drain;
  logic [63:0]   base_pc;
  logic [63:0]   next_pc;
  branch_pred_t  pred;
  logic          slot_valid_0, slot_valid_1;
  fetch_packet_t next_pkt;

  // redirect targets are word aligned; the two low bits are never stored
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^io_redirect_target[1:0];

  assign base_pc      = align_pc(fetch_pc);
  assign drain        = pkt_valid & ~io_full;
  assign io_out_valid = drain;

  // a new request may go out while the current packet drains, giving one packet per two cycles
  assign io_imem_req_valid = reset && (state == ST_REQ) && (!pkt_valid || drain) && !io_redirect_valid;
  assign io_imem_req_addr  = io_imem_req_valid ? base_pc : '0;

`ifdef FETCH_STATIC_PREDICT_EN
  fetch_predecode u_predecode (
    .inst_0      (io_imem_resp_data[31:0]),
    .inst_1      (io_imem_resp_data[63:32]),
    .valid_0     (~fetch_pc[2]),
    .valid_1     (1'b1),
    .base_pc     (base_pc),
    .pred        (pred),
    .valid_out_0 (slot_valid_0),
    .valid_out_1 (slot_valid_1),
    .next_pc     (next_pc)
  );
`else
  assign pred         = '0;
  assign slot_valid_0 = ~fetch_pc[2];
  assign slot_valid_1 = 1'b1;
  assign next_pc      = base_pc + 64'(FETCH_BYTES);
`endif

  always_comb begin
    next_pkt         = '0;
    next_pkt.valid_0 = slot_valid_0;
    next_pkt.valid_1 = slot_valid_1;
    next_pkt.pc      = base_pc;
    next_pkt.inst_0  = io_imem_resp_data[31:0];
    next_pkt.inst_1  = io_imem_resp_data[63:32];
    next_pkt.pred    = pred;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_REQ;
      fetch_pc  <= RESET_PC;
      pkt_valid <= 1'b0;
      pkt       <= '0;
    end else if (io_redirect_valid) begin
      fetch_pc  <= {io_redirect_target[63:2], 2'b00};
      pkt_valid <= 1'b0;
      // a response arriving now retires the outstanding request, so no drop is needed
      state     <= (state != ST_REQ && !io_imem_resp_valid) ? ST_DROP : ST_REQ;
    end else begin
      if (drain) pkt_valid <= 1'b0;
      case (state)
        ST_REQ:  if (io_imem_req_valid && io_imem_req_ready) state <= ST_WAIT;
        ST_WAIT: if (io_imem_resp_valid) begin
          pkt       <= next_pkt;
          pkt_valid <= 1'b1;
          fetch_pc  <= next_pc;
          state     <= ST_REQ;
        end
        ST_DROP: if (io_imem_resp_valid) state <= ST_REQ;
        default: state <= ST_REQ;
      endcase
    end
  end

  assign io_out_bits_valids_0                   = pkt.valid_0;
  assign io_out_bits_valids_1                   = pkt.valid_1;
  assign io_out_bits_pc                         = pkt.pc;
  assign io_out_bits_insts_0                    = pkt.inst_0;
  assign io_out_bits_insts_1                    = pkt.inst_1;
  assign io_out_bits_branch_predict_pack_valid  = pkt.pred.pred_valid;
  assign io_out_bits_branch_predict_pack_target = pkt.pred.pred_target;
  assign io_out_bits_branch_predict_pack_taken  = pkt.pred.pred_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against a transaction-level reference model
module tb_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int NCYC    = 3000;
  localparam int RST_AT  = 1500;
  localparam int FULL_AT = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_redirect_valid = 1'b0;
  logic [63:0] io_redirect_target = '0;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready = 1'b0;
  logic [63:0] io_imem_req_addr;
  logic        io_imem_resp_valid = 1'b0;
  logic [63:0] io_imem_resp_data = '0;
  logic        io_full = 1'b0;
  logic        io_out_valid;
  logic        io_out_bits_valids_0, io_out_bits_valids_1;
  logic [63:0] io_out_bits_pc;
  logic [31:0] io_out_bits_insts_0, io_out_bits_insts_1;
  logic        io_out_bits_branch_predict_pack_valid;
  logic [63:0] io_out_bits_branch_predict_pack_target;
  logic        io_out_bits_branch_predict_pack_taken;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .io_redirect_valid(io_redirect_valid), .io_redirect_target(io_redirect_target),
    .io_imem_req_valid(io_imem_req_valid), .io_imem_req_ready(io_imem_req_ready),
    .io_imem_req_addr(io_imem_req_addr),
    .io_imem_resp_valid(io_imem_resp_valid), .io_imem_resp_data(io_imem_resp_data),
    .io_full(io_full), .io_out_valid(io_out_valid),
    .io_out_bits_valids_0(io_out_bits_valids_0), .io_out_bits_valids_1(io_out_bits_valids_1),
    .io_out_bits_pc(io_out_bits_pc),
    .io_out_bits_insts_0(io_out_bits_insts_0), .io_out_bits_insts_1(io_out_bits_insts_1),
    .io_out_bits_branch_predict_pack_valid(io_out_bits_branch_predict_pack_valid),
    .io_out_bits_branch_predict_pack_target(io_out_bits_branch_predict_pack_target),
    .io_out_bits_branch_predict_pack_taken(io_out_bits_branch_predict_pack_taken)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        v0, v1;
    logic [63:0] pc;
    logic [31:0] i0, i1;
    logic        pv, pt;
    logic [63:0] ptgt;
    logic [63:0] npc;
  } exp_pkt_t;

  // instruction memory contents: hashed words, roughly half of them branches or JALs
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] h;
    if (a == 64'h8000_0010) return 32'hFE0008E3;  // beq x0,x0,-16
    h = (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
    h = h ^ (h >> 15);
    h = h * 32'h85EB_CA6B;
    h = h ^ (h >> 13);
    case (h[9:8])
      2'd0:    h[6:0] = 7'b1100011;
      2'd1:    h[6:0] = 7'b1101111;
      default: ;
    endcase
    return h;
  endfunction

  // expected packet and following fetch PC for a fetch starting at fpc
  function automatic exp_pkt_t model_packet(input logic [63:0] fpc);
    exp_pkt_t p;
    logic [63:0] base;
    base   = fpc & ~64'h7;
    p.pc   = base;
    p.i0   = mem_word(base);
    p.i1   = mem_word(base + 64'd4);
    p.v0   = ~fpc[2];
    p.v1   = 1'b1;
    p.pv   = 1'b0;
    p.pt   = 1'b0;
    p.ptgt = '0;
    p.npc  = base + 64'd8;
`ifdef FETCH_STATIC_PREDICT_EN
    for (int s = 0; s < 2; s++) begin
      logic [31:0] w;
      longint      off;
      bit          tk;
      w = (s == 0) ? p.i0 : p.i1;
      if (s == 0 && !p.v0) continue;
      if (w[6:0] == 7'b1101111) begin
        off = longint'(w[30:21]) * 2 + longint'(w[20]) * 2048 + longint'(w[19:12]) * 4096
              - (w[31] ? 1048576 : 0);
        tk  = 1'b1;
      end else if (w[6:0] == 7'b1100011) begin
        off = longint'(w[11:8]) * 2 + longint'(w[30:25]) * 32 + longint'(w[7]) * 2048
              - (w[31] ? 4096 : 0);
        tk  = w[31];
      end else begin
        continue;
      end
      p.pv = 1'b1;
      if (tk) begin
        p.pt   = 1'b1;
        p.ptgt = base + 64'(4 * s) + 64'(off);
        p.npc  = p.ptgt;
        if (s == 0) p.v1 = 1'b0;
        break;
      end
    end
`endif
    return p;
  endfunction

  task automatic check_pkt(input exp_pkt_t p);
    check("out_pc",        io_out_bits_pc, p.pc);
    check("out_valids_0",  io_out_bits_valids_0, p.v0);
    check("out_valids_1",  io_out_bits_valids_1, p.v1);
    check("out_insts_0",   io_out_bits_insts_0, p.i0);
    check("out_insts_1",   io_out_bits_insts_1, p.i1);
    check("pred_valid",    io_out_bits_branch_predict_pack_valid, p.pv);
    check("pred_taken",    io_out_bits_branch_predict_pack_taken, p.pt);
    check("pred_target",   io_out_bits_branch_predict_pack_target, p.ptgt);
  endtask

  exp_pkt_t    sb[$];
  logic [63:0] exp_pc;
  bit          mem_busy, mem_stale, chk_lat, busy_now;
  logic [63:0] mem_fpc, base;
  int          mem_cnt;
  int          transfers = 0;

  initial begin
    exp_pkt_t p;
    exp_pc    = RESET_PC;
    mem_busy  = 1'b0;
    mem_stale = 1'b0;
    chk_lat   = 1'b0;
    mem_cnt   = 0;
    mem_fpc   = '0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clock);
      reset = !(cyc < 3 || (cyc >= RST_AT && cyc < RST_AT + 3));
      io_full = (cyc >= FULL_AT && cyc < FULL_AT + 5) ? 1'b1 : ($urandom_range(0, 3) == 0);
      io_imem_req_ready = ($urandom_range(0, 3) != 0);
      io_redirect_valid = 1'b0;
      io_redirect_target = {$urandom, $urandom};
      if (reset) begin
        if (cyc == 20)       begin io_redirect_valid = 1'b1; io_redirect_target = 64'h8000_0104; end
        else if (cyc == 40)  begin io_redirect_valid = 1'b1; io_redirect_target = 64'h8000_0010; end
        else if (cyc == 70)  begin io_redirect_valid = 1'b1; io_redirect_target = 64'hFFFF_FFFF_FFFF_FFFE; end
        else if ($urandom_range(0, 23) == 0) begin
          io_redirect_valid  = 1'b1;
          io_redirect_target = RESET_PC + 64'($urandom_range(0, 8191));
        end
      end
      base = mem_fpc & ~64'h7;
      io_imem_resp_valid = reset ? (mem_busy && mem_cnt == 0) : ($urandom_range(0, 1) == 1);
      io_imem_resp_data  = mem_busy ? {mem_word(base + 64'd4), mem_word(base)} : {$urandom, $urandom};
      #1;

      if (!reset) begin
        check("rst_out_valid", io_out_valid, 0);
        check("rst_req_valid", io_imem_req_valid, 0);
        check("rst_req_addr",  io_imem_req_addr, 0);
        check("rst_out_pc",    io_out_bits_pc, 0);
        check("rst_out_insts", {io_out_bits_insts_1, io_out_bits_insts_0}, 0);
        check("rst_out_valids", {io_out_bits_valids_1, io_out_bits_valids_0}, 0);
        check("rst_pred", {io_out_bits_branch_predict_pack_valid, io_out_bits_branch_predict_pack_taken}, 0);
        check("rst_pred_target", io_out_bits_branch_predict_pack_target, 0);
        sb.delete();
        mem_busy = 1'b0;
        chk_lat  = 1'b0;
        exp_pc   = RESET_PC;
        continue;
      end

      busy_now = mem_busy;
      if (io_full) check("out_valid_when_full", io_out_valid, 0);
      if (chk_lat && !io_full) check("resp_to_out_latency", io_out_valid, 1);
      chk_lat = 1'b0;
      if (sb.size() > 0) check_pkt(sb[0]);
      if (io_out_valid) begin
        transfers++;
        if (sb.size() == 0) check("unexpected_out_valid", io_out_valid, 0);
        else void'(sb.pop_front());
      end

      if (!io_redirect_valid && !busy_now && sb.size() == 0)
        check("req_valid_expected", io_imem_req_valid, 1);
      if (io_imem_req_valid) begin
        check("req_while_outstanding", busy_now, 0);
        check("req_during_redirect", io_redirect_valid, 0);
        check("req_with_packet_held", sb.size(), 0);
        check("req_addr", io_imem_req_addr, exp_pc & ~64'h7);
      end

      if (io_imem_resp_valid && busy_now) begin
        if (!mem_stale && !io_redirect_valid) begin
          p = model_packet(mem_fpc);
          sb.push_back(p);
          exp_pc  = p.npc;
          chk_lat = 1'b1;
        end
        mem_busy = 1'b0;
      end else if (busy_now) begin
        mem_cnt--;
      end

      if (io_imem_req_valid && io_imem_req_ready) begin
        mem_busy  = 1'b1;
        mem_stale = 1'b0;
        mem_fpc   = exp_pc;
        mem_cnt   = $urandom_range(0, 2);
      end

      if (io_redirect_valid) begin
        sb.delete();
        exp_pc  = io_redirect_target & ~64'h3;
        chk_lat = 1'b0;
        if (mem_busy) mem_stale = 1'b1;
      end
    end
    check("packets_delivered_min200", transfers >= 200, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
